// File: rtl/sub_pkg.sv
// Shared constants for the registered sign-magnitude subtractor.
package sub_pkg;

  // Default operand / result width in bits.
  localparam int WIDTH_DEF = 4;

endpackage : sub_pkg

// File: rtl/sub_borrow_chain.sv
// Combinational ripple-borrow subtractor: {diff} = A - B, borrow_out = (A < B).
import sub_pkg::*;

module sub_borrow_chain #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // borrow[i] is the borrow into bit i; no borrow enters the LSB.
  logic [WIDTH:0] borrow;

  assign borrow[0] = 1'b0;

  // One full subtractor per bit, borrow rippling towards the MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign diff[i]     = A[i] ^ B[i] ^ borrow[i];
    assign borrow[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow[i]);
  end

  // Borrow out of the MSB is bit WIDTH of {1'b0,A} - {1'b0,B}, i.e. the sign.
  assign borrow_out = borrow[WIDTH];

endmodule : sub_borrow_chain

// File: rtl/sub.sv
// Registered unsigned subtractor producing sign (buho) and magnitude (sum).
import sub_pkg::*;

module sub #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  output logic             buho,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic [WIDTH-1:0] mag;

  sub_borrow_chain #(
    .WIDTH(WIDTH)
  ) u_chain (
    .A         (A),
    .B         (B),
    .diff      (diff),
    .borrow_out(borrow_out)
  );

  // A negative raw difference is turned into its magnitude by two's-complement
  // negation; |A-B| always fits in WIDTH bits so no overflow handling is needed.
  assign mag = borrow_out ? (~diff + WIDTH'(1)) : diff;

  // Output registers: cleared asynchronously, loaded only on enabled edges.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buho <= 1'b0;
      sum  <= '0;
    end else if (start) begin
      buho <= borrow_out;
      sum  <= mag;
    end
  end

endmodule : sub

// File: tb/tb_sub.sv
// Self-checking bench for sub: vector table, corner sequences, random stream
// against an arithmetic reference model, and an exhaustive operand sweep.
module tb_sub;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic         clk;
  logic         n_rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         start;
  logic         buho;
  logic [W-1:0] sum;

  int tests;
  int fails;

  // Reference model state: what the outputs should currently show.
  logic         m_buho;
  logic [W-1:0] m_sum;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         eb;
    logic [W-1:0] es;
  } vec_t;

  vec_t vecs[9];

  sub #(.WIDTH(W)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .A    (A),
    .B    (B),
    .start(start),
    .buho (buho),
    .sum  (sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sign and magnitude of a - b from plain integer arithmetic.
  function automatic logic ref_sign(input logic [W-1:0] a, input logic [W-1:0] b);
    return (int'(a) - int'(b)) < 0;
  endfunction

  function automatic logic [W-1:0] ref_mag(input logic [W-1:0] a, input logic [W-1:0] b);
    int d;
    d = int'(a) - int'(b);
    if (d < 0) d = -d;
    return d[W-1:0];
  endfunction

  task automatic check(input string name, input logic eb, input logic [W-1:0] es);
    tests++;
    if ($isunknown({buho, sum}) || buho !== eb || sum !== es) begin
      fails++;
      $display("FAIL %s: got buho=%b sum=%0d, expected buho=%b sum=%0d (t=%0t)",
               name, buho, sum, eb, es, $time);
    end
  endtask

  // Drive operands after the falling edge, then sample 1 time unit past the
  // next rising edge; the model mirrors the spec's update rule.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic st);
    @(negedge clk);
    A     = a;
    B     = b;
    start = st;
    @(posedge clk);
    if (st) begin
      m_buho = ref_sign(a, b);
      m_sum  = ref_mag(a, b);
    end
    #1;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    m_buho = 1'b0;
    m_sum  = '0;

    vecs[0] = '{a: 4'd4,  b: 4'd3,  eb: 1'b0, es: 4'd1};
    vecs[1] = '{a: 4'd9,  b: 4'd2,  eb: 1'b0, es: 4'd7};
    vecs[2] = '{a: 4'd2,  b: 4'd5,  eb: 1'b1, es: 4'd3};
    vecs[3] = '{a: 4'd0,  b: 4'd15, eb: 1'b1, es: 4'd15};
    vecs[4] = '{a: 4'd2,  b: 4'd2,  eb: 1'b0, es: 4'd0};
    vecs[5] = '{a: 4'd15, b: 4'd0,  eb: 1'b0, es: 4'd15};
    vecs[6] = '{a: 4'd0,  b: 4'd0,  eb: 1'b0, es: 4'd0};
    vecs[7] = '{a: 4'd15, b: 4'd15, eb: 1'b0, es: 4'd0};
    vecs[8] = '{a: 4'd7,  b: 4'd8,  eb: 1'b1, es: 4'd1};

    // Reset held from t=0 with the clock running, even across an enabled edge.
    n_rst = 1'b0;
    A     = '0;
    B     = '0;
    start = 1'b0;
    #2;
    check("reset_early", 1'b0, 4'd0);
    A     = 4'd15;
    B     = 4'd0;
    start = 1'b1;
    #4;
    check("reset_edge", 1'b0, 4'd0);
    #1;
    n_rst = 1'b1;
    start = 1'b0;
    #1;
    check("reset_release", 1'b0, 4'd0);

    // Table-driven vectors with spec-fixed expected values.
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].a, vecs[i].b, 1'b1);
      check($sformatf("vec%0d", i), vecs[i].eb, vecs[i].es);
    end

    // Hold: outputs keep the loaded result while start is low.
    apply(4'd7, 4'd9, 1'b1);
    check("hold_load", 1'b1, 4'd2);
    for (int i = 0; i < 3; i++) begin
      apply(4'd1, 4'd0, 1'b0);
      check($sformatf("hold_%0d", i), 1'b1, 4'd2);
    end
    apply(4'd1, 4'd0, 1'b1);
    check("hold_resume", 1'b0, 4'd1);

    // Inputs changing mid-cycle do not reach the outputs before an edge.
    @(negedge clk);
    A = 4'd0;
    B = 4'd9;
    start = 1'b1;
    #2;
    check("midcycle", 1'b0, 4'd1);
    @(posedge clk);
    #1;
    check("midcycle_load", 1'b1, 4'd9);
    m_buho = 1'b1;
    m_sum  = 4'd9;

    // Random stream with random enables against the model.
    for (int i = 0; i < 200; i++) begin
      apply(W'($urandom), W'($urandom), 1'(($urandom_range(0, 3) != 0)));
      check("stream", m_buho, m_sum);
    end

    // Mid-stream reset pulse between edges, then fresh operands load.
    apply(4'd3, 4'd12, 1'b1);
    check("pre_reset", 1'b1, 4'd9);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("midreset_clear", 1'b0, 4'd0);
    #1;
    n_rst = 1'b1;
    A = 4'd13;
    B = 4'd6;
    start = 1'b1;
    #1;
    check("midreset_hold", 1'b0, 4'd0);
    @(posedge clk);
    #1;
    check("midreset_resume", 1'b0, 4'd7);

    // Exhaustive sweep of all operand pairs.
    for (int a = 0; a <= MAX; a++) begin
      for (int b = 0; b <= MAX; b++) begin
        apply(W'(a), W'(b), 1'b1);
        check($sformatf("sweep_%0d_%0d", a, b), m_buho, m_sum);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sub
